// File: rtl/sa_input_skewer.sv
// Systolic-array input skewer: reads NUM_ROWS activation words from BRAM and
// presents them diagonally so that lane i trails lane 0 by i cycles.
module sa_input_skewer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PE_SIZE    = 16,
    parameter int unsigned NUM_ROWS   = 64,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           stall_i,
    output logic                           mem_ce_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0]  mem_q_i,
    output logic [DATA_WIDTH*PE_SIZE-1:0]  data_o,
    output logic [PE_SIZE-1:0]             valid_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned CNT_MAX = (NUM_ROWS > PE_SIZE + 2) ? NUM_ROWS : PE_SIZE + 2;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam int unsigned WW      = DATA_WIDTH * PE_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_rd_cnt;
    logic [CW-1:0]   w_rd_cnt_nxt;
    logic [CW-1:0]   r_drain_cnt;
    logic [CW-1:0]   w_drain_cnt_nxt;
    logic            w_ce;
    logic            w_done;
    logic            r_busy;
    logic            r_rd_vld;
    logic            r_skid_v;
    logic [WW-1:0]   r_skid;
    logic [WW-1:0]   w_word;
    logic            w_in_vld;

    // State, counters and busy flag; everything holds while stalled except in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rd_cnt    <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state, counter updates, read enable and done pulse
    always_comb begin
        w_state_nxt     = r_state;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_ce            = 1'b0;
        w_done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt     = S_READ;
                    w_rd_cnt_nxt    = '0;
                    w_drain_cnt_nxt = '0;
                end
            end
            S_READ: begin
                if (!stall_i) begin
                    w_ce         = 1'b1;
                    w_rd_cnt_nxt = r_rd_cnt + CW'(1);
                    if (r_rd_cnt == CW'(NUM_ROWS - 1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Last word leaves lane PE_SIZE-1 after PE_SIZE+1 unstalled drain cycles
                if (!stall_i) begin
                    if (r_drain_cnt == CW'(PE_SIZE)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt + CW'(1);
                    end
                end
            end
            S_DONE: begin
                if (!stall_i) begin
                    w_done          = 1'b1;
                    w_state_nxt     = S_IDLE;
                    w_rd_cnt_nxt    = '0;
                    w_drain_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_ce_o   = w_ce;
    assign mem_addr_o = ADDR_WIDTH'(BASE_ADDR + 32'(r_rd_cnt));
    assign busy_o     = r_busy;
    assign done_o     = w_done;

    // Read-valid tracking and one-entry skid that catches data returning during a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= 1'b0;
            r_skid_v <= 1'b0;
            r_skid   <= '0;
        end else begin
            r_rd_vld <= w_ce;
            if (stall_i) begin
                if (r_rd_vld) begin
                    r_skid   <= mem_q_i;
                    r_skid_v <= 1'b1;
                end
            end else begin
                r_skid_v <= 1'b0;
            end
        end
    end

    assign w_word   = r_skid_v ? r_skid : mem_q_i;
    assign w_in_vld = r_skid_v | r_rd_vld;

    for (genvar gi = 0; gi < PE_SIZE; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_sh [0:gi];
        logic [gi:0]           r_v;

        // Lane gi delay chain of gi+1 stages; invalid slots carry zero data
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= gi; j++) begin
                    r_sh[j] <= '0;
                end
                r_v <= '0;
            end else if (!stall_i) begin
                r_sh[0] <= w_in_vld ? w_word[WW-1-gi*DATA_WIDTH -: DATA_WIDTH] : '0;
                r_v[0]  <= w_in_vld;
                for (int j = 1; j <= gi; j++) begin
                    r_sh[j] <= r_sh[j-1];
                    r_v[j]  <= r_v[j-1];
                end
            end
        end

        assign data_o[WW-1-gi*DATA_WIDTH -: DATA_WIDTH] = r_sh[gi];
        assign valid_o[gi]                              = r_v[gi];
    end

endmodule

// File: tb/tb_sa_input_skewer.sv
// Directed bench for sa_input_skewer: skew timing, stalls, restart, reset, wrap.
module tb_sa_input_skewer;

    localparam int unsigned DW = 8;
    localparam int unsigned PE = 4;
    localparam int unsigned AW = 7;
    localparam int unsigned WW = DW * PE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // dut0: NUM_ROWS=3, BASE_ADDR=0
    logic start0 = 1'b0, stall0 = 1'b0, ce0, busy0, done0;
    logic [AW-1:0] addr0;
    logic [WW-1:0] q0 = '0, data0;
    logic [PE-1:0] valid0;
    // dut1: NUM_ROWS=1
    logic start1 = 1'b0, stall1 = 1'b0, ce1, busy1, done1;
    logic [AW-1:0] addr1;
    logic [WW-1:0] q1 = '0, data1;
    logic [PE-1:0] valid1;
    // dut2: NUM_ROWS=4, BASE_ADDR=126
    logic start2 = 1'b0, stall2 = 1'b0, ce2, busy2, done2;
    logic [AW-1:0] addr2;
    logic [WW-1:0] q2 = '0, data2;
    logic [PE-1:0] valid2;

    sa_input_skewer #(.DATA_WIDTH(DW), .PE_SIZE(PE), .NUM_ROWS(3), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .stall_i(stall0), .mem_ce_o(ce0),
        .mem_addr_o(addr0), .mem_q_i(q0), .data_o(data0), .valid_o(valid0), .busy_o(busy0), .done_o(done0));
    sa_input_skewer #(.DATA_WIDTH(DW), .PE_SIZE(PE), .NUM_ROWS(1), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .stall_i(stall1), .mem_ce_o(ce1),
        .mem_addr_o(addr1), .mem_q_i(q1), .data_o(data1), .valid_o(valid1), .busy_o(busy1), .done_o(done1));
    sa_input_skewer #(.DATA_WIDTH(DW), .PE_SIZE(PE), .NUM_ROWS(4), .ADDR_WIDTH(AW), .BASE_ADDR(126)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .stall_i(stall2), .mem_ce_o(ce2),
        .mem_addr_o(addr2), .mem_q_i(q2), .data_o(data2), .valid_o(valid2), .busy_o(busy2), .done_o(done2));

    // BRAM word k holds lanes {k*16+0, k*16+1, k*16+2, k*16+3}, lane 0 in the MSBs
    function automatic logic [WW-1:0] bram_word(input logic [AW-1:0] a);
        logic [7:0] b;
        b = {a[3:0], 4'h0};
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    always @(posedge clk) begin
        if (ce0) q0 <= bram_word(addr0);
        if (ce1) q1 <= bram_word(addr1);
        if (ce2) q2 <= bram_word(addr2);
    end

    // Unstalled NUM_ROWS=3 job, start in cycle 0; index = cycle
    logic [WW-1:0] exp_data [0:10] = '{32'h0, 32'h0, 32'h0, 32'h00000000, 32'h10010000, 32'h20110200,
                                       32'h00211203, 32'h00002213, 32'h00000023, 32'h0, 32'h0};
    logic [PE-1:0] exp_valid [0:10] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    logic [AW-1:0] exp_addr [0:10] = '{7'd0, 7'd0, 7'd1, 7'd2, 7'd3, 7'd3, 7'd3, 7'd3, 7'd3, 7'd3, 7'd0};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (data0 !== '0)   begin n_errors++; $display("FAIL reset_data got %h exp 0", data0); end
        n_checks++; if (valid0 !== '0)  begin n_errors++; $display("FAIL reset_valid got %h exp 0", valid0); end
        n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
        n_checks++; if (done0 !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done0); end
        n_checks++; if (ce0 !== 1'b0)   begin n_errors++; $display("FAIL reset_ce got %b exp 0", ce0); end
        n_checks++; if (addr0 !== 7'd0) begin n_errors++; $display("FAIL reset_addr got %0d exp 0", addr0); end
        n_checks++; if (addr2 !== 7'd126) begin n_errors++; $display("FAIL reset_addr_base got %0d exp 126", addr2); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_basic();
        for (int c = 0; c <= 10; c++) begin
            start0 = (c == 0);
            @(negedge clk);
            n_checks++; if (data0 !== exp_data[c])   begin n_errors++; $display("FAIL basic_data c=%0d got %h exp %h", c, data0, exp_data[c]); end
            n_checks++; if (valid0 !== exp_valid[c]) begin n_errors++; $display("FAIL basic_valid c=%0d got %b exp %b", c, valid0, exp_valid[c]); end
            n_checks++; if (busy0 !== (c >= 1 && c <= 9)) begin n_errors++; $display("FAIL basic_busy c=%0d got %b", c, busy0); end
            n_checks++; if (done0 !== (c == 9)) begin n_errors++; $display("FAIL basic_done c=%0d got %b", c, done0); end
            n_checks++; if (ce0 !== (c >= 1 && c <= 3)) begin n_errors++; $display("FAIL basic_ce c=%0d got %b", c, ce0); end
            n_checks++; if (addr0 !== exp_addr[c]) begin n_errors++; $display("FAIL basic_addr c=%0d got %0d exp %0d", c, addr0, exp_addr[c]); end
            next_cycle();
        end
        start0 = 1'b0;
    endtask

    task automatic test_stall_read();
        logic [WW-1:0] ed;
        logic [PE-1:0] ev;
        for (int c = 0; c <= 13; c++) begin
            start0 = (c == 0);
            stall0 = (c >= 2 && c <= 4);
            ed = '0;
            ev = '0;
            if (c >= 3) begin
                ed = exp_data[c-3];
                ev = exp_valid[c-3];
            end
            @(negedge clk);
            n_checks++; if (data0 !== ed)  begin n_errors++; $display("FAIL stall_data c=%0d got %h exp %h", c, data0, ed); end
            n_checks++; if (valid0 !== ev) begin n_errors++; $display("FAIL stall_valid c=%0d got %b exp %b", c, valid0, ev); end
            n_checks++; if (ce0 !== (c == 1 || c == 5 || c == 6)) begin n_errors++; $display("FAIL stall_ce c=%0d got %b", c, ce0); end
            n_checks++; if (done0 !== (c == 12)) begin n_errors++; $display("FAIL stall_done c=%0d got %b", c, done0); end
            n_checks++; if (busy0 !== (c >= 1 && c <= 12)) begin n_errors++; $display("FAIL stall_busy c=%0d got %b", c, busy0); end
            next_cycle();
        end
        start0 = 1'b0;
        stall0 = 1'b0;
    endtask

    task automatic test_double_start();
        int n_done;
        n_done = 0;
        for (int c = 0; c <= 13; c++) begin
            start0 = (c == 0 || c == 4);
            @(negedge clk);
            if (done0 === 1'b1) n_done++;
            if (c <= 10) begin
                n_checks++; if (addr0 !== exp_addr[c]) begin n_errors++; $display("FAIL dbl_addr c=%0d got %0d exp %0d", c, addr0, exp_addr[c]); end
            end else begin
                n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL dbl_restart c=%0d busy got %b exp 0", c, busy0); end
            end
            next_cycle();
        end
        start0 = 1'b0;
        n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL dbl_done_count got %0d exp 1", n_done); end
    endtask

    task automatic test_reset_mid();
        int n_done;
        for (int c = 0; c <= 4; c++) begin
            start0 = (c == 0);
            next_cycle();
        end
        start0 = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (data0 !== '0)   begin n_errors++; $display("FAIL rstmid_data got %h exp 0", data0); end
        n_checks++; if (valid0 !== '0)  begin n_errors++; $display("FAIL rstmid_valid got %b exp 0", valid0); end
        n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b exp 0", busy0); end
        n_checks++; if (ce0 !== 1'b0)   begin n_errors++; $display("FAIL rstmid_ce got %b exp 0", ce0); end
        n_checks++; if (addr0 !== 7'd0) begin n_errors++; $display("FAIL rstmid_addr got %0d exp 0", addr0); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) n_done++;
            next_cycle();
        end
        n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL rstmid_no_done got %0d active cycles exp 0", n_done); end
        test_basic();
    endtask

    task automatic test_stall_start();
        for (int c = 0; c <= 10; c++) begin
            start0 = (c == 0);
            stall0 = (c == 0);
            @(negedge clk);
            if (c == 1) begin
                n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL stlstart_busy got %b exp 1", busy0); end
                n_checks++; if (ce0 !== 1'b1)   begin n_errors++; $display("FAIL stlstart_ce got %b exp 1", ce0); end
            end
            n_checks++; if (done0 !== (c == 9)) begin n_errors++; $display("FAIL stlstart_done c=%0d got %b", c, done0); end
            next_cycle();
        end
        start0 = 1'b0;
        stall0 = 1'b0;
    endtask

    task automatic test_stall_done();
        for (int c = 0; c <= 12; c++) begin
            start0 = (c == 0);
            stall0 = (c == 9);
            @(negedge clk);
            n_checks++; if (done0 !== (c == 10)) begin n_errors++; $display("FAIL stldone_done c=%0d got %b", c, done0); end
            n_checks++; if (busy0 !== (c >= 1 && c <= 10)) begin n_errors++; $display("FAIL stldone_busy c=%0d got %b", c, busy0); end
            next_cycle();
        end
        start0 = 1'b0;
        stall0 = 1'b0;
    endtask

    task automatic test_single_row();
        logic [WW-1:0] ed [0:8] = '{32'h0, 32'h0, 32'h0, 32'h00000000, 32'h00010000, 32'h00000200, 32'h00000003, 32'h0, 32'h0};
        logic [PE-1:0] ev [0:8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
        for (int c = 0; c <= 8; c++) begin
            start1 = (c == 0);
            @(negedge clk);
            n_checks++; if (valid1 !== ev[c]) begin n_errors++; $display("FAIL one_valid c=%0d got %b exp %b", c, valid1, ev[c]); end
            n_checks++; if (data1 !== ed[c])  begin n_errors++; $display("FAIL one_data c=%0d got %h exp %h", c, data1, ed[c]); end
            n_checks++; if (done1 !== (c == 7)) begin n_errors++; $display("FAIL one_done c=%0d got %b", c, done1); end
            n_checks++; if (busy1 !== (c >= 1 && c <= 7)) begin n_errors++; $display("FAIL one_busy c=%0d got %b", c, busy1); end
            next_cycle();
        end
        start1 = 1'b0;
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] ea [0:5] = '{7'd126, 7'd126, 7'd127, 7'd0, 7'd1, 7'd2};
        for (int c = 0; c <= 11; c++) begin
            start2 = (c == 0);
            @(negedge clk);
            if (c <= 5) begin
                n_checks++; if (addr2 !== ea[c]) begin n_errors++; $display("FAIL wrap_addr c=%0d got %0d exp %0d", c, addr2, ea[c]); end
            end
            n_checks++; if (ce2 !== (c >= 1 && c <= 4)) begin n_errors++; $display("FAIL wrap_ce c=%0d got %b", c, ce2); end
            n_checks++; if (done2 !== (c == 10)) begin n_errors++; $display("FAIL wrap_done c=%0d got %b", c, done2); end
            next_cycle();
        end
        start2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_read();
        test_double_start();
        test_reset_mid();
        test_stall_start();
        test_stall_done();
        test_single_row();
        test_addr_wrap();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
